qsys_system_key_piano: RTL and testbench
========================================

# qsys_system_key_piano

Avalon-MM slave input port, the counterpart to the piano LED output port. It samples the board piano keys, synchronises them and optionally debounces them. It latches press events in an edge-capture register and raises a maskable interrupt to the Nios II. It sits in the Qsys system beside the LED output port, on the same data-master bus and clock domain.

## Interface
Parameters:
- WIDTH, 7, number of key inputs (one per piano note).
- INVERT, 1, 1 = raw in_port is active-low (board KEY/SW idle high) and is inverted before sync; 0 = active-high.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a key change is accepted (1 ms at 50 MHz); legal range 2..2^20.

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous key inputs.
- readdata  out  32  read data, zero-extended.
- irq  out  1  level interrupt, active-high.

## Operation
- Input path per bit: optional inversion, 2-flop synchroniser, debouncer, then `stable` register.
- Debouncer, per bit: a counter clears whenever the sync output equals `stable`. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, `stable` takes the sync value and the counter clears. Any glitch back to `stable` restarts the count.
- Edge capture: a bit of edge_capture sets on the clock edge where its `stable` bit goes 0->1 (key press). Releases are not captured. The bit stays set until software clears it.
- Register map (read latency 0; readdata is combinational from registers; bits above WIDTH read 0):
  - 0 DATA: read-only, the `stable` value. Writes are ignored.
  - 1: reserved, reads 0, writes ignored.
  - 2 IRQMASK: read/write, writedata[WIDTH-1:0].
  - 3 EDGECAPTURE: read; writing 1 to a bit clears that bit; writing 0 leaves it unchanged.
- A write occurs when chipselect && !write_n.
- irq = |(edge_capture & irq_mask).
- Simultaneous set and clear on the same bit in the same cycle: set wins, and the bit stays 1.
- Reset values: sync flops, stable, counters, edge_capture and irq_mask are 0, so readdata and irq are 0. A key held during reset is reported after release of reset plus normal latency, and it produces a capture event.

## Timing
- With debounce, a clean in_port step at clock edge N is handled as follows:
  - The sync output changes at edge N+2.
  - `stable` and the edge_capture bit update at edge N+1+DEBOUNCE_CYCLES.
  - irq asserts in the same cycle if the bit is unmasked.
- Without debounce, `stable` equals the sync output, so the latency is 2 edges and edge_capture sets at edge N+2.
- Register writes take effect at the next clock edge.
- irq deasserts the cycle after the clearing write or mask write.
- Reset is asynchronous. Asserting it mid-count discards the partial count and any pending capture.

## Configuration
- KEY_PIANO_DEBOUNCE_EN defined: per-bit debounce counters are instantiated as described.
- KEY_PIANO_DEBOUNCE_EN undefined: no counters are built, DEBOUNCE_CYCLES is ignored, and `stable` is the synchroniser output. All registers and irq behaviour are otherwise identical.

## Structure
- Package qsys_system_key_piano_pkg holds:
  - the address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - a counter-width helper function giving $clog2(DEBOUNCE_CYCLES).
- Sub-module qsys_system_key_debounce is a single-bit synchroniser plus debouncer with output `stable`. It is instantiated WIDTH times in a generate loop. The debounce counter inside it is under the macro.

## Test plan
- Reset with in_port=7'h7F (INVERT=1, idle): reads of addresses 0, 2 and 3 return 0 and irq=0.
- DEBOUNCE_CYCLES=4. Drive in_port[2] low cleanly at edge N:
  - DATA reads 0x04 from edge N+5.
  - EDGECAPTURE reads 0x04.
  - irq stays 0 with the mask at 0.
- Bounce in_port[0] low, high, low with periods shorter than 4 cycles, then hold it low: exactly one capture occurs, 5 edges after the final transition.
- Write IRQMASK=0x04 with edge_capture[2] set: irq=1 on the next cycle. Write 0x04 to address 3: edge_capture becomes 0 and irq=0 on the next cycle.
- A press on bit 1 completes in the same cycle as a write of 0x02 to address 3: edge_capture[1] remains 1.
- KEY_PIANO_DEBOUNCE_EN undefined: a single-cycle press on bit 6 produces a capture 2 edges later, and a release is not captured.

Source files
------------

// File: rtl/qsys_system_key_piano_pkg.sv
// Shared constants for the piano key input port: register addresses and
// the debounce counter sizing helper.
package qsys_system_key_piano_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Bits needed to hold a count of 0..DEBOUNCE_CYCLES-1.
  function automatic int cnt_width(input int debounce_cycles);
    return (debounce_cycles < 2) ? 1 : $clog2(debounce_cycles);
  endfunction

endpackage

// File: rtl/qsys_system_key_debounce.sv
// Single key input: optional inversion, 2-flop synchroniser and, when
// KEY_PIANO_DEBOUNCE_EN is defined, a stability counter in front of the
// `stable` register. `rise` is high on the cycle whose closing edge moves
// `stable` from 0 to 1, so the capture register sets on that same edge.
module qsys_system_key_debounce
  import qsys_system_key_piano_pkg::*;
#(
  parameter int INVERT          = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable,
  output logic rise
);

  logic din_x;
  logic s1;
  logic s2;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES out of range 2..2^20");
  end

  assign din_x = (INVERT != 0) ? ~din : din;

  // Two-flop synchroniser for the asynchronous board input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din_x;
      s2 <= s1;
    end
  end

`ifdef KEY_PIANO_DEBOUNCE_EN
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  // The sync value has already differed for one cycle when the counter
  // first sees it, so accepting at DEBOUNCE_CYCLES-2 lands the update on
  // edge N+1+DEBOUNCE_CYCLES for a step at edge N.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [CW-1:0] cnt;
  logic          stable_q;
  logic          stable_d;

  // Next stable value: take the sync value once it has held long enough.
  always_comb begin
    stable_d = stable_q;
    if (s2 != stable_q && cnt == CNT_LAST) stable_d = s2;
  end

  // Count consecutive cycles the sync value differs from stable; any
  // return to the stable value restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
      if (s2 == stable_q || cnt == CNT_LAST) cnt <= '0;
      else                                   cnt <= cnt + 1'b1;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_d & ~stable_q;
`else
  assign stable = s2;
  assign rise   = s1 & ~s2;
`endif

endmodule

// File: rtl/qsys_system_key_piano.sv
// Avalon-MM piano key input port. Keys are synchronised (and debounced
// when KEY_PIANO_DEBOUNCE_EN is defined), presses are latched in an
// edge-capture register with write-1-to-clear, and a maskable level irq
// is raised. Registers: 0 DATA, 2 IRQMASK, 3 EDGECAPTURE.
module qsys_system_key_piano
  import qsys_system_key_piano_pkg::*;
#(
  parameter int WIDTH           = 7,
  parameter int INVERT          = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    qsys_system_key_debounce #(
      .INVERT          (INVERT),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .stable  (stable[i]),
      .rise    (rise[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Bits written as 1 to EDGECAPTURE are cleared this edge.
  always_comb begin
    cap_clr = '0;
    if (wr_en && address == ADDR_EDGECAP) cap_clr = writedata[WIDTH-1:0];
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              irq_mask <= '0;
    else if (wr_en && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
  end

  // Press capture; a new press wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~cap_clr) | rise;
  end

  // Zero-latency read mux, zero-extended.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_qsys_system_key_piano.sv
// Bench for qsys_system_key_piano (WIDTH=7, INVERT=1, DEBOUNCE_CYCLES=4).
// A reference model tracks the synchronised key history per edge and
// applies the acceptance rule on a sliding window; every cycle readdata
// and irq are compared against it, plus a register-map table and directed
// timing sequences.
module tb_qsys_system_key_piano;
  import qsys_system_key_piano_pkg::*;

  localparam int W  = 7;
  localparam int DC = 4;
`ifdef KEY_PIANO_DEBOUNCE_EN
  localparam int LAT = DC + 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '1;
  logic [31:0]   readdata;
  logic          irq;

  always #5 clk = ~clk;

  qsys_system_key_piano #(.WIDTH(W), .INVERT(1), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: sq[i] = pressed-key vector sampled at edge i+1
  // since reset release.
  logic [W-1:0] sq[$];
  int           t;
  logic [W-1:0] m_stable, m_cap, m_mask;
  logic [W-1:0] keys_q = '0;

  function automatic logic [W-1:0] sync_at(input int k);
    if (k < 2) return '0;
    return sq[k-2];
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    if (a == ADDR_DATA)    r[W-1:0] = m_stable;
    if (a == ADDR_IRQMASK) r[W-1:0] = m_mask;
    if (a == ADDR_EDGECAP) r[W-1:0] = m_cap;
    return r;
  endfunction

  task automatic model_reset();
    sq.delete();
    t = 0;
    m_stable = '0;
    m_cap = '0;
    m_mask = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] nxt, clr, s;
    bit all_diff;
    sq.push_back(~in_port);
    t++;
`ifdef KEY_PIANO_DEBOUNCE_EN
    // A bit flips once the last DC-1 synchronised samples all disagree.
    nxt = m_stable;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = t - DC + 1; j <= t - 1; j++) begin
        s = sync_at(j);
        if (s[b] == m_stable[b]) all_diff = 1'b0;
      end
      if (all_diff) nxt[b] = ~m_stable[b];
    end
`else
    nxt = sync_at(t);
`endif
    clr = '0;
    if (chipselect && !write_n && address == 2'd3) clr = writedata[W-1:0];
    m_cap = (m_cap & ~clr) | (nxt & ~m_stable);
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_stable = nxt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive just after an edge, compare at negedge, advance
  // the model across the next edge.
  task automatic cyc(input logic [1:0] a, input logic cs, input logic wn,
                     input logic [31:0] wd, output logic [31:0] rd, output logic iq);
    address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = ~keys_q;
    @(negedge clk);
    rd = readdata;
    iq = irq;
    check("model_rd", rd, model_rd(a));
    check("model_irq", {31'b0, iq}, {31'b0, |(m_cap & m_mask)});
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] rd, output logic iq);
    cyc(a, 1'b1, 1'b1, 32'h0, rd, iq);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] rd; logic iq;
    cyc(a, 1'b1, 1'b0, wd, rd, iq);
  endtask

  task automatic do_reset();
    logic [31:0] rd; logic iq;
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      rd_reg(2'(i == 0 ? 0 : i + 1), rd, iq);
      check("reset_rd", rd, 32'h0);
      check("reset_irq", {31'b0, iq}, 32'h0);
    end
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[14];
  int   hold[W];

  initial begin
    logic [31:0] rd;
    logic iq;
    int r;

    tbl[0]  = '{2'd2, 1'b1, 1'b0, 32'h55,       32'h00, 1'b0};
    tbl[1]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h55, 1'b0};
    tbl[2]  = '{2'd0, 1'b1, 1'b0, 32'h7F,       32'h00, 1'b0};
    tbl[3]  = '{2'd0, 1'b1, 1'b1, 32'h0,        32'h00, 1'b0};
    tbl[4]  = '{2'd1, 1'b1, 1'b0, 32'hFF,       32'h00, 1'b0};
    tbl[5]  = '{2'd1, 1'b1, 1'b1, 32'h0,        32'h00, 1'b0};
    tbl[6]  = '{2'd2, 1'b0, 1'b0, 32'h0,        32'h55, 1'b0};
    tbl[7]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h55, 1'b0};
    tbl[8]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h55, 1'b0};
    tbl[9]  = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h55, 1'b0};
    tbl[10] = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h7F, 1'b0};
    tbl[11] = '{2'd3, 1'b1, 1'b0, 32'h7F,       32'h00, 1'b0};
    tbl[12] = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h7F, 1'b0};
    tbl[13] = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h00, 1'b0};

    // Reset with all keys idle (in_port high).
    keys_q = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Register map.
    foreach (tbl[i]) begin
      cyc(tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd, rd, iq);
      check("tbl_rd", rd, tbl[i].exp_rd);
      check("tbl_irq", {31'b0, iq}, {31'b0, tbl[i].exp_irq});
    end

    // Clean press of key 2.
    keys_q = 7'h04;
    for (int i = 0; i <= LAT + 1; i++) begin
      rd_reg(ADDR_DATA, rd, iq);
      if (i == LAT - 1) check("press_data_pre", rd, 32'h0);
      if (i == LAT)     check("press_data_post", rd, 32'h04);
    end
    rd_reg(ADDR_EDGECAP, rd, iq);
    check("press_cap", rd, 32'h04);
    check("press_irq_masked", {31'b0, iq}, 32'h0);

    // Unmask then clear.
    wr_reg(ADDR_IRQMASK, 32'h04);
    rd_reg(ADDR_EDGECAP, rd, iq);
    check("irq_set", {31'b0, iq}, 32'h1);
    wr_reg(ADDR_EDGECAP, 32'h04);
    rd_reg(ADDR_EDGECAP, rd, iq);
    check("clr_cap", rd, 32'h0);
    check("clr_irq", {31'b0, iq}, 32'h0);

    // Release is not captured.
    keys_q = '0;
    for (int i = 0; i <= LAT + 1; i++) rd_reg(ADDR_EDGECAP, rd, iq);
    check("release_nocap", rd, 32'h0);
    rd_reg(ADDR_DATA, rd, iq);
    check("release_data", rd, 32'h0);

`ifdef KEY_PIANO_DEBOUNCE_EN
    // Bouncing key 0: 2 pressed, 2 released, then held; one capture
    // LAT edges after the final transition (call 4).
    for (int i = 0; i <= 4 + LAT + 3; i++) begin
      keys_q = (i < 2 || i >= 4) ? 7'h01 : 7'h00;
      rd_reg(ADDR_EDGECAP, rd, iq);
      if (i == 3)           check("bounce_early", rd, 32'h0);
      if (i == 4 + LAT - 1) check("bounce_pre", rd, 32'h0);
      if (i == 4 + LAT)     check("bounce_post", rd, 32'h01);
    end
    wr_reg(ADDR_EDGECAP, 32'h01);
    keys_q = '0;
    for (int i = 0; i <= LAT + 1; i++) rd_reg(ADDR_EDGECAP, rd, iq);
    check("bounce_single", rd, 32'h0);
`endif

    // Capture on key 1 lands on the same edge as a clear of bit 1.
    keys_q = 7'h02;
    for (int i = 0; i <= LAT; i++) begin
      if (i == LAT - 1) wr_reg(ADDR_EDGECAP, 32'h02);
      else              rd_reg(ADDR_EDGECAP, rd, iq);
      if (i == LAT) check("set_wins", rd, 32'h02);
    end
    rd_reg(ADDR_EDGECAP, rd, iq);
    check("irq_set_wins_masked", {31'b0, iq}, 32'h0);
    wr_reg(ADDR_EDGECAP, 32'h02);
    keys_q = '0;
    for (int i = 0; i <= LAT + 1; i++) rd_reg(ADDR_EDGECAP, rd, iq);
    check("set_wins_cleared", rd, 32'h0);

    // Single-cycle press of key 6.
    keys_q = 7'h40;
    rd_reg(ADDR_EDGECAP, rd, iq);
    keys_q = '0;
    rd_reg(ADDR_EDGECAP, rd, iq);
    check("pulse_pre", rd, 32'h0);
    rd_reg(ADDR_EDGECAP, rd, iq);
`ifdef KEY_PIANO_DEBOUNCE_EN
    check("pulse_filtered", rd, 32'h0);
`else
    check("pulse_cap", rd, 32'h40);
    wr_reg(ADDR_EDGECAP, 32'h40);
`endif
    for (int i = 0; i <= LAT + 1; i++) rd_reg(ADDR_EDGECAP, rd, iq);
    check("pulse_release_nocap", rd, 32'h0);

    // Reset mid-count with key 3 held: reported again after release.
    keys_q = 7'h08;
    rd_reg(ADDR_EDGECAP, rd, iq);
    rd_reg(ADDR_EDGECAP, rd, iq);
    do_reset();
    for (int i = 0; i <= LAT + 1; i++) begin
      rd_reg(ADDR_EDGECAP, rd, iq);
      if (i == LAT - 1) check("held_reset_pre", rd, 32'h0);
      if (i == LAT)     check("held_reset_post", rd, 32'h08);
    end
    wr_reg(ADDR_EDGECAP, 32'h08);
    keys_q = '0;
    for (int i = 0; i <= LAT + 1; i++) rd_reg(ADDR_EDGECAP, rd, iq);

    // Random keys with mixed hold lengths and random bus traffic.
    for (int b = 0; b < W; b++) hold[b] = $urandom_range(1, 8);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < W; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          keys_q[b] = ~keys_q[b];
          hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
        end
      end
      if (i == 1500) do_reset();
      r = $urandom_range(0, 9);
      if (r < 3) wr_reg(2'($urandom_range(0, 3)), $urandom);
      else       rd_reg(2'($urandom_range(0, 3)), rd, iq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
